// File: rtl/riscv_pkg.sv
// Shared definitions for the parametrised RISC-V register file.
//   XLEN_DEF / NREGS_DEF : default data width and architectural register count
//   ZERO_REG_IDX         : index of the hardwired-zero register (x0)
//   rf_state_e           : clear-sequencer state (INIT clears the array, RUN is normal operation)
package riscv_pkg;

    localparam int XLEN_DEF     = 32;
    localparam int NREGS_DEF    = 32;
    localparam int ZERO_REG_IDX = 0;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } rf_state_e;

endpackage

// File: rtl/regfile_bypass_mux.sv
// Read-port selection for one combinational register-file read port.
//   run      : array is initialised; while low the port reads 0
//   rs_addr  : read address
//   arr_data : raw array contents at rs_addr
//   we, rd_addr, rd_wdata : same-cycle core write, forwarded when BYPASS is set
//   rs_data  : selected read value
// Priority: not running / out of range / hardwired x0 -> 0, then bypass, then array.
module regfile_bypass_mux
    import riscv_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int NREGS    = NREGS_DEF,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1,
    localparam int AW      = $clog2(NREGS)
)(
    input  logic            run,
    input  logic [AW-1:0]   rs_addr,
    input  logic [XLEN-1:0] arr_data,
    input  logic            we,
    input  logic [AW-1:0]   rd_addr,
    input  logic [XLEN-1:0] rd_wdata,
    output logic [XLEN-1:0] rs_data
);

    localparam logic [AW:0]   NREGS_W = (AW+1)'(NREGS);
    localparam logic [AW-1:0] X0_ADDR = AW'(ZERO_REG_IDX);

    logic in_range;
    logic is_x0;
    logic hit;

    assign in_range = ({1'b0, rs_addr} < NREGS_W);
    assign is_x0    = ZERO_REG && (rs_addr == X0_ADDR);
    // An in-range, non-x0 read address equal to rd_addr implies the core
    // write itself is legal, so no separate write-validity term is needed.
    assign hit      = BYPASS && we && (rd_addr == rs_addr);

    always_comb begin
        rs_data = arr_data;
        if (!run || !in_range || is_x0) begin
            rs_data = '0;
        end else if (hit) begin
            rs_data = rd_wdata;
        end
    end

endmodule

// File: rtl/riscv_regfile_dbg.sv
// Parametrised register file with post-reset clear sequencer, optional
// write-to-read bypass and a handshaked debug access port.
//   clk, rst (async, active-low)
//   rs_addr / rs_data       : NRD combinational read ports, packed per port
//   we, rd_addr, rd_wdata   : core write port
//   dbg_req, dbg_we, dbg_addr, dbg_wdata : debug request (level, held until ack)
//   dbg_ack                 : one-cycle acknowledge, cycle after acceptance
//   dbg_rdata               : pre-write register value captured at acceptance
//   init_done               : high once every register has been cleared
module riscv_regfile_dbg
    import riscv_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int NREGS    = NREGS_DEF,
    parameter int NRD      = 2,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1,
    localparam int AW      = $clog2(NREGS)
)(
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   rs_addr,
    output logic [NRD*XLEN-1:0] rs_data,
    input  logic                we,
    input  logic [AW-1:0]       rd_addr,
    input  logic [XLEN-1:0]     rd_wdata,
    input  logic                dbg_req,
    input  logic                dbg_we,
    input  logic [AW-1:0]       dbg_addr,
    input  logic [XLEN-1:0]     dbg_wdata,
    output logic                dbg_ack,
    output logic [XLEN-1:0]     dbg_rdata,
    output logic                init_done
);

    localparam logic [AW:0]   NREGS_W = (AW+1)'(NREGS);
    localparam logic [AW-1:0] X0_ADDR = AW'(ZERO_REG_IDX);
    localparam logic [AW-1:0] LAST    = AW'(NREGS - 1);

    logic [XLEN-1:0] regs [NREGS];
    rf_state_e       state;
    rf_state_e       state_nxt;
    logic [AW-1:0]   clr_ptr;
    logic            run;
    logic            accept;
    logic            core_wr;
    logic            dbg_wr;
    logic [XLEN-1:0] dbg_rd_val;

    // Address is a real, writable register (in range and not hardwired x0).
    function automatic logic addr_wr(input logic [AW-1:0] a);
        return ({1'b0, a} < NREGS_W) && !(ZERO_REG && (a == X0_ADDR));
    endfunction

    assign run = (state == RUN);

    // A debug write yields to a core write; a debug read never does.
    // Blocking during the ack cycle limits throughput to one access per two cycles.
    assign accept  = run && dbg_req && !dbg_ack && !(dbg_we && we);
    assign core_wr = run && we && addr_wr(rd_addr);
    assign dbg_wr  = accept && dbg_we && addr_wr(dbg_addr);

    // Debug reads see the array before this cycle's write, never the bypass path.
    assign dbg_rd_val = addr_wr(dbg_addr) ? regs[dbg_addr] : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= INIT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if ((state == INIT) && (clr_ptr == LAST)) begin
            state_nxt = RUN;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clr_ptr   <= '0;
            init_done <= 1'b0;
        end else begin
            if (state == INIT) begin
                clr_ptr <= clr_ptr + AW'(1);
            end
            init_done <= (state_nxt == RUN);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dbg_ack   <= 1'b0;
            dbg_rdata <= '0;
        end else begin
            dbg_ack <= accept;
            if (accept) begin
                dbg_rdata <= dbg_rd_val;
            end
        end
    end

    // The array has no reset; the clear sequencer zeroes it one entry per cycle.
    // Core and debug writes are mutually exclusive by the acceptance rule.
    always_ff @(posedge clk) begin
        if (state == INIT) begin
            regs[clr_ptr] <= '0;
        end else if (core_wr) begin
            regs[rd_addr] <= rd_wdata;
        end else if (dbg_wr) begin
            regs[dbg_addr] <= dbg_wdata;
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0] a;
        assign a = rs_addr[i*AW +: AW];

        regfile_bypass_mux #(
            .XLEN     (XLEN),
            .NREGS    (NREGS),
            .ZERO_REG (ZERO_REG),
            .BYPASS   (BYPASS)
        ) u_mux (
            .run      (run),
            .rs_addr  (a),
            .arr_data (regs[a]),
            .we       (we),
            .rd_addr  (rd_addr),
            .rd_wdata (rd_wdata),
            .rs_data  (rs_data[i*XLEN +: XLEN])
        );
    end

endmodule

// File: tb/tb_riscv_regfile_dbg.sv
// Bench for riscv_regfile_dbg: two instances share all inputs.
//   dut_a : defaults (NREGS=32, BYPASS=1)
//   dut_b : NREGS=24, BYPASS=0 (exercises out-of-range addresses and no bypass)
// A driver issues directed then random stimulus and pushes expected outputs,
// computed from a plain array model, into queues; a monitor on the falling
// edge pops and compares.
module tb_riscv_regfile_dbg;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  rs_addr = '0;
    logic        we = 1'b0;
    logic [4:0]  rd_addr = '0;
    logic [31:0] rd_wdata = '0;
    logic        dbg_req = 1'b0;
    logic        dbg_we = 1'b0;
    logic [4:0]  dbg_addr = '0;
    logic [31:0] dbg_wdata = '0;

    logic [63:0] rs_data_a, rs_data_b;
    logic        ack_a, ack_b, done_a, done_b;
    logic [31:0] rdata_a, rdata_b;

    always #5 clk = ~clk;

    riscv_regfile_dbg dut_a (
        .clk(clk), .rst(rst), .rs_addr(rs_addr), .rs_data(rs_data_a),
        .we(we), .rd_addr(rd_addr), .rd_wdata(rd_wdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_ack(ack_a), .dbg_rdata(rdata_a), .init_done(done_a)
    );

    riscv_regfile_dbg #(.NREGS(24), .BYPASS(1'b0)) dut_b (
        .clk(clk), .rst(rst), .rs_addr(rs_addr), .rs_data(rs_data_b),
        .we(we), .rd_addr(rd_addr), .rd_wdata(rd_wdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_ack(ack_b), .dbg_rdata(rdata_b), .init_done(done_b)
    );

    typedef struct packed {
        logic [1:0]       ack;
        logic [1:0]       done;
        logic [3:0][31:0] rs;
    } exp_t;

    exp_t        q_rd[$];
    logic [31:0] q_dbg0[$];
    logic [31:0] q_dbg1[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Reference model: register contents, init countdown, ack state.
    logic [31:0] mem [2][32];
    bit          m_done [2];
    int          m_cnt [2];
    bit          m_ack [2];

    function automatic int nregs(input int k);
        return (k == 0) ? 32 : 24;
    endfunction

    function automatic bit m_valid(input int k, input logic [4:0] a);
        return (a != 5'd0) && (int'(a) < nregs(k));
    endfunction

    function automatic logic [31:0] m_read(input int k, input logic [4:0] a);
        if (!m_done[k] || !m_valid(k, a)) return 32'd0;
        if ((k == 0) && we && (rd_addr == a)) return rd_wdata;
        return mem[k][a];
    endfunction

    task automatic m_edge(input int k);
        bit acc;
        if (!m_done[k]) begin
            m_ack[k] = 1'b0;
            m_cnt[k]++;
            if (m_cnt[k] == nregs(k)) begin
                m_done[k] = 1'b1;
                for (int i = 0; i < 32; i++) mem[k][i] = 32'd0;
            end
            return;
        end
        acc = dbg_req && !m_ack[k] && !(dbg_we && we);
        if (acc) begin
            if (k == 0) q_dbg0.push_back(m_valid(k, dbg_addr) ? mem[k][dbg_addr] : 32'd0);
            else        q_dbg1.push_back(m_valid(k, dbg_addr) ? mem[k][dbg_addr] : 32'd0);
        end
        if (we && m_valid(k, rd_addr)) mem[k][rd_addr] = rd_wdata;
        if (acc && dbg_we && m_valid(k, dbg_addr)) mem[k][dbg_addr] = dbg_wdata;
        m_ack[k] = acc;
    endtask

    task automatic m_reset();
        for (int k = 0; k < 2; k++) begin
            m_done[k] = 1'b0;
            m_cnt[k]  = 0;
            m_ack[k]  = 1'b0;
        end
        q_dbg0.delete();
        q_dbg1.delete();
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, act, want);
        end
    endtask

    // Called at posedge+2 with inputs already set for this cycle.
    task automatic step();
        exp_t e;
        for (int k = 0; k < 2; k++) begin
            e.ack[k]  = m_ack[k];
            e.done[k] = m_done[k];
            for (int p = 0; p < 2; p++) e.rs[k*2+p] = m_read(k, rs_addr[p*5 +: 5]);
        end
        q_rd.push_back(e);
        @(posedge clk);
        if (rst) begin
            m_edge(0);
            m_edge(1);
        end
        cyc++;
        #2;
    endtask

    task automatic wait_ack();
        int n = 0;
        step();
        while (!m_ack[0] && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (!m_ack[0]) begin
            errors++;
            $display("FAIL dbg_wait cyc=%0d got=no_ack expected=ack", cyc);
        end
        dbg_req = 1'b0;
    endtask

    task automatic dbg_op(input bit w, input logic [4:0] a, input logic [31:0] d);
        dbg_req = 1'b1; dbg_we = w; dbg_addr = a; dbg_wdata = d;
        wait_ack();
        step();
    endtask

    task automatic pulse_reset();
        rst = 1'b0;
        m_reset();
        step();
        rst = 1'b1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q_rd.size() != 0) begin
            e = q_rd.pop_front();
            chk("rs0_a",  rs_data_a[31:0],  e.rs[0]);
            chk("rs1_a",  rs_data_a[63:32], e.rs[1]);
            chk("rs0_b",  rs_data_b[31:0],  e.rs[2]);
            chk("rs1_b",  rs_data_b[63:32], e.rs[3]);
            chk("ack_a",  {31'd0, ack_a},   {31'd0, e.ack[0]});
            chk("ack_b",  {31'd0, ack_b},   {31'd0, e.ack[1]});
            chk("done_a", {31'd0, done_a},  {31'd0, e.done[0]});
            chk("done_b", {31'd0, done_b},  {31'd0, e.done[1]});
            if (ack_a) begin
                if (q_dbg0.size() == 0) chk("rdata_a_unexp_ack", 32'd1, 32'd0);
                else chk("rdata_a", rdata_a, q_dbg0.pop_front());
            end
            if (ack_b) begin
                if (q_dbg1.size() == 0) chk("rdata_b_unexp_ack", 32'd1, 32'd0);
                else chk("rdata_b", rdata_b, q_dbg1.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        m_reset();
        #1 rst = 1'b0;
        @(posedge clk);
        #2;
        for (int i = 0; i < 3; i++) step();

        // Release reset; core write during INIT must be ignored.
        rst = 1'b1;
        we = 1'b1; rd_addr = 5'd5; rd_wdata = 32'hDEAD; rs_addr = {5'd5, 5'd5};
        for (int i = 0; i < 20; i++) step();
        we = 1'b0;
        for (int i = 0; i < 14; i++) step();

        // Debug writes, then read back through core ports.
        dbg_op(1'b1, 5'd1, 32'd5);
        dbg_op(1'b1, 5'd2, 32'd7);
        rs_addr = {5'd2, 5'd1};
        step();

        // Same-cycle bypass (dut_a) versus old value (dut_b).
        we = 1'b1; rd_addr = 5'd3; rd_wdata = 32'h1234; rs_addr = {5'd1, 5'd3};
        step();
        we = 1'b0;
        step();

        // Debug write held off by three cycles of core writes.
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd4; dbg_wdata = 32'hAA;
        we = 1'b1; rd_addr = 5'd10; rd_wdata = 32'h1010;
        for (int i = 0; i < 3; i++) step();
        we = 1'b0;
        wait_ack();
        step();

        // Debug read of x4 concurrent with core write of x4.
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd4;
        we = 1'b1; rd_addr = 5'd4; rd_wdata = 32'h55;
        step();
        we = 1'b0;
        rs_addr = {5'd10, 5'd4};
        wait_ack();
        step();

        // Writes to hardwired x0.
        we = 1'b1; rd_addr = 5'd0; rd_wdata = 32'hFFFF; rs_addr = {5'd0, 5'd0};
        step();
        we = 1'b0;
        dbg_op(1'b1, 5'd0, 32'h77);
        dbg_op(1'b0, 5'd0, 32'd0);
        step();

        // Address 30: out of range for the 24-entry instance.
        we = 1'b1; rd_addr = 5'd30; rd_wdata = 32'h3030;
        step();
        we = 1'b0; rs_addr = {5'd30, 5'd30};
        step();
        dbg_op(1'b1, 5'd30, 32'h99);
        dbg_op(1'b0, 5'd30, 32'd0);

        // Reset while a debug request is pending.
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd2;
        pulse_reset();
        for (int i = 0; i < 5; i++) step();
        dbg_req = 1'b0;
        for (int i = 0; i < 30; i++) step();
        for (int a = 0; a < 32; a++) begin
            rs_addr = {5'(31 - a), 5'(a)};
            step();
        end

        // Random traffic.
        for (int c = 0; c < 400; c++) begin
            if (dbg_req && m_ack[0]) begin
                dbg_req = 1'b0;
            end else if (!dbg_req && ($urandom_range(0, 2) == 0)) begin
                dbg_req   = 1'b1;
                dbg_we    = 1'($urandom_range(0, 1));
                dbg_addr  = 5'($urandom_range(0, 31));
                dbg_wdata = $urandom;
            end
            we       = 1'($urandom_range(0, 1));
            rd_addr  = 5'($urandom_range(0, 31));
            rd_wdata = $urandom;
            rs_addr  = 10'($urandom_range(0, 1023));
            step();
        end
        dbg_req = 1'b0; we = 1'b0;
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
